// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects and
// shadow-slot descriptors.
package pipe_pkg;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWR = 2'd2;

  // Slot address field is sized for the widest supported register file
  localparam int SLOT_AW = 8;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rw;
    logic               reg_wr;
    logic               load;
  } slot_t;

  // m[0]=EX, m[1]=MEM: youngest producer wins
  function automatic logic [1:0] fwd_pick(input logic [2:0] m);
    if (m[0]) return FWD_EXMEM;
    if (m[1]) return FWD_MEMWR;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/pipe_hazard_if.sv
// ID-stage / hazard-unit handshake bundle.
// Counter signals exist only with PIPE_HAZARD_PERF_EN defined.
interface pipe_hazard_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);

  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [ADDR_W-1:0] id_rw;
  logic              id_reg_wr;
  logic              id_mem_to_reg;
  logic              ex_branch_taken;

  logic              pc_hold;
  logic              ifid_hold;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              id_byp_a;
  logic              id_byp_b;

  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be at least 1");
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    output id_rw, id_reg_wr, id_mem_to_reg, ex_branch_taken,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble,
    input  fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_rw, id_reg_wr, id_mem_to_reg, ex_branch_taken,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble,
    output fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b,
    output stall_cnt, flush_cnt
  );
`else
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    output id_rw, id_reg_wr, id_mem_to_reg, ex_branch_taken,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble,
    input  fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_rw, id_reg_wr, id_mem_to_reg, ex_branch_taken,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble,
    output fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b
  );
`endif

endinterface

// File: rtl/hazard_match.sv
// Compares one ID source register against one in-flight shadow slot.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              i_use,
  input  logic [ADDR_W-1:0] i_src,
  input  slot_t             i_slot,
  output logic              o_match,
  output logic              o_load_match
);

  logic [SLOT_AW-1:0] w_src;

  assign w_src = SLOT_AW'(i_src);

  // r0 is hard-wired zero, so it never carries a dependency
  assign o_match = i_use
                && (i_src != '0)
                && i_slot.valid
                && i_slot.reg_wr
                && (i_slot.rw == w_src);

  assign o_load_match = o_match && i_slot.load;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection / forwarding control for the 5-stage pipeline.
// Optional perf counters: define PIPE_HAZARD_PERF_EN.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input logic         clk,
  input logic         rst_n,
  pipe_hazard_if.slave hz
);

  if (ADDR_W > SLOT_AW) begin : g_bad_aw
    $error("ADDR_W exceeds slot address width");
  end
  if (LOAD_STALL != 1 && LOAD_STALL != 2) begin : g_bad_ls
    $error("LOAD_STALL must be 1 or 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be at least 1");
  end

  slot_t r_ex;
  slot_t r_mem;
  slot_t r_wr;
  slot_t w_id;
  slot_t w_slot [3];

  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;
  logic [1:0]        w_use;
  logic [ADDR_W-1:0] w_src [2];
  logic [1:0][2:0]   w_m;
  logic [1:0][2:0]   w_lm;
  logic              w_stall;
  logic              w_flush;
  logic              w_bubble;
  logic              w_unused;

  assign w_slot[0] = r_ex;
  assign w_slot[1] = r_mem;
  assign w_slot[2] = r_wr;

  assign w_use[0] = hz.id_valid && hz.id_use_rs;
  assign w_use[1] = hz.id_valid && hz.id_use_rt;
  assign w_src[0] = hz.id_rs;
  assign w_src[1] = hz.id_rt;

  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar k = 0; k < 3; k++) begin : g_slot
      hazard_match #(
        .ADDR_W (ADDR_W)
      ) u_match (
        .i_use        (w_use[s]),
        .i_src        (w_src[s]),
        .i_slot       (w_slot[k]),
        .o_match      (w_m[s][k]),
        .o_load_match (w_lm[s][k])
      );
    end
  end

  // A load in WR has already delivered its data
  assign w_unused = &{1'b0, w_lm[0][2], w_lm[1][2]};

  assign w_stall = w_lm[0][0] || w_lm[1][0]
                || ((LOAD_STALL == 2)
                    && (w_lm[0][1] || w_lm[1][1]));

  assign w_flush  = hz.ex_branch_taken;
  assign w_bubble = w_stall || w_flush;

  assign hz.pc_hold     = w_stall && !w_flush;
  assign hz.ifid_hold   = w_stall && !w_flush;
  assign hz.ifid_flush  = w_flush;
  assign hz.idex_bubble = w_bubble;

  assign hz.id_byp_a = w_m[0][2] && !w_m[0][0] && !w_m[0][1];
  assign hz.id_byp_b = w_m[1][2] && !w_m[1][0] && !w_m[1][1];

  assign hz.fwd_a_sel = r_fwd_a;
  assign hz.fwd_b_sel = r_fwd_b;

  always_comb begin
    w_id = '0;
    if (hz.id_valid && !w_bubble) begin
      w_id.valid  = 1'b1;
      w_id.rw     = SLOT_AW'(hz.id_rw);
      w_id.reg_wr = hz.id_reg_wr;
      w_id.load   = hz.id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wr    <= '0;
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else begin
      r_ex    <= w_id;
      r_mem   <= r_ex;
      r_wr    <= r_mem;
      r_fwd_a <= w_bubble ? FWD_REG : fwd_pick(w_m[0]);
      r_fwd_b <= w_bubble ? FWD_REG : fwd_pick(w_m[1]);
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !w_flush)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scenario bench for pipe_hazard_unit (LOAD_STALL=1).
// ctl bits: {pc_hold, ifid_hold, ifid_flush, idex_bubble, byp_a, byp_b}.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_if #(.ADDR_W(5), .CNT_W(32)) hz ();

  pipe_hazard_unit #(
    .ADDR_W     (5),
    .LOAD_STALL (1),
    .CNT_W      (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int n_pass = 0;
  int n_chk  = 0;
  logic [3:0] q_fwd [$];
  logic [3:0] w_exp;
  int exp_sc = 0;
  int exp_fc = 0;

  logic [5:0] w_ctl;
  assign w_ctl = {hz.pc_hold, hz.ifid_hold, hz.ifid_flush,
                  hz.idex_bubble, hz.id_byp_a, hz.id_byp_b};

  logic [3:0] w_fwd;
  assign w_fwd = {hz.fwd_a_sel, hz.fwd_b_sel};

  task automatic drv(input logic v, input logic [4:0] rs,
                     input logic [4:0] rt, input logic ua,
                     input logic ub, input logic [4:0] rw,
                     input logic wr, input logic ld,
                     input logic br);
    hz.id_valid        = v;
    hz.id_rs           = rs;
    hz.id_rt           = rt;
    hz.id_use_rs       = ua;
    hz.id_use_rt       = ub;
    hz.id_rw           = rw;
    hz.id_reg_wr       = wr;
    hz.id_mem_to_reg   = ld;
    hz.ex_branch_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    n_chk++;
    if (w_ctl !== 6'b0) $display("FAIL reset_ctl got %b want %b", w_ctl, 6'b0);
    else n_pass++;
    n_chk++;
    if (w_fwd !== 4'h0) $display("FAIL reset_fwd got %h want %h", w_fwd, 4'h0);
    else n_pass++;
`ifdef PIPE_HAZARD_PERF_EN
    n_chk++;
    if (hz.stall_cnt !== 0 || hz.flush_cnt !== 0)
      $display("FAIL reset_cnt got %0d/%0d want 0/0", hz.stall_cnt, hz.flush_cnt);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_fwd();
    idle(3);
    // add r3,r1,r2
    drv(1, 1, 2, 1, 1, 3, 1, 0, 0);
    #1;
    q_fwd.push_back(4'b00_00);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL alu_add_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
    // sub r4,r3,r1
    drv(1, 3, 1, 1, 1, 4, 1, 0, 0);
    #1;
    n_chk++;
    if (w_ctl !== 6'b0) $display("FAIL alu_sub_ctl got %b want %b", w_ctl, 6'b0);
    else n_pass++;
    q_fwd.push_back(4'b01_00);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL alu_sub_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
    // add r7,r3,r4: r3 in MEM, r4 in EX
    drv(1, 3, 4, 1, 1, 7, 1, 0, 0);
    #1;
    q_fwd.push_back(4'b10_01);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL alu_mix_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
  endtask

  task automatic test_youngest();
    idle(3);
    drv(1, 1, 0, 1, 0, 9, 1, 0, 0);
    tick();
    drv(1, 2, 0, 1, 0, 9, 1, 0, 0);
    tick();
    drv(1, 9, 9, 1, 1, 10, 1, 0, 0);
    #1;
    q_fwd.push_back(4'b01_01);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL youngest_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
  endtask

  task automatic test_load_use();
    idle(3);
    // lw r5,0(r1)
    drv(1, 1, 0, 1, 0, 5, 1, 1, 0);
    #1;
    q_fwd.push_back(4'b00_00);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL lu_lw_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
    // add r6,r5,r5
    drv(1, 5, 5, 1, 1, 6, 1, 0, 0);
    #1;
    n_chk++;
    if (w_ctl !== 6'b110100) $display("FAIL lu_stall_ctl got %b want %b", w_ctl, 6'b110100);
    else n_pass++;
    q_fwd.push_back(4'b00_00);
    tick();
    exp_sc++;
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL lu_bubble_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
    n_chk++;
    if (w_ctl !== 6'b0) $display("FAIL lu_release_ctl got %b want %b", w_ctl, 6'b0);
    else n_pass++;
    q_fwd.push_back(4'b10_10);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL lu_add_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
`ifdef PIPE_HAZARD_PERF_EN
    n_chk++;
    if (hz.stall_cnt !== exp_sc) $display("FAIL lu_stall_cnt got %0d want %0d", hz.stall_cnt, exp_sc);
    else n_pass++;
`endif
  endtask

  task automatic test_bypass();
    idle(3);
    drv(1, 1, 2, 1, 1, 7, 1, 0, 0);
    tick();
    drv(1, 1, 2, 1, 1, 8, 1, 0, 0);
    tick();
    drv(1, 1, 2, 1, 1, 9, 1, 0, 0);
    tick();
    // producer of r7 now in WR
    drv(1, 7, 1, 1, 1, 11, 1, 0, 0);
    #1;
    n_chk++;
    if (w_ctl !== 6'b000010) $display("FAIL byp_ctl got %b want %b", w_ctl, 6'b000010);
    else n_pass++;
    q_fwd.push_back(4'b00_00);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL byp_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
  endtask

  task automatic test_r0();
    idle(3);
    // addi r0,r1,7
    drv(1, 1, 0, 1, 0, 0, 1, 0, 0);
    tick();
    drv(1, 0, 0, 1, 1, 8, 1, 0, 0);
    #1;
    n_chk++;
    if (w_ctl !== 6'b0) $display("FAIL r0_alu_ctl got %b want %b", w_ctl, 6'b0);
    else n_pass++;
    q_fwd.push_back(4'b00_00);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL r0_alu_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
    // lw r0 then reader of r0
    drv(1, 1, 0, 1, 0, 0, 1, 1, 0);
    tick();
    drv(1, 0, 0, 1, 1, 8, 1, 0, 0);
    #1;
    n_chk++;
    if (w_ctl !== 6'b0) $display("FAIL r0_load_ctl got %b want %b", w_ctl, 6'b0);
    else n_pass++;
  endtask

  task automatic test_id_invalid();
    idle(3);
    drv(1, 1, 0, 1, 0, 5, 1, 1, 0);
    tick();
    drv(0, 5, 5, 1, 1, 6, 1, 0, 0);
    #1;
    n_chk++;
    if (w_ctl !== 6'b0) $display("FAIL inv_ctl got %b want %b", w_ctl, 6'b0);
    else n_pass++;
    q_fwd.push_back(4'b00_00);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL inv_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
    // load now in MEM: no stall, forward from MEM/WR
    drv(1, 5, 1, 1, 0, 6, 1, 0, 0);
    #1;
    n_chk++;
    if (w_ctl !== 6'b0) $display("FAIL inv_mem_ctl got %b want %b", w_ctl, 6'b0);
    else n_pass++;
    q_fwd.push_back(4'b10_00);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL inv_mem_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
  endtask

  task automatic test_branch_stall();
    idle(3);
    drv(1, 1, 0, 1, 0, 5, 1, 1, 0);
    tick();
    drv(1, 5, 5, 1, 1, 6, 1, 0, 1);
    #1;
    n_chk++;
    if (w_ctl !== 6'b001100) $display("FAIL br_ctl got %b want %b", w_ctl, 6'b001100);
    else n_pass++;
    q_fwd.push_back(4'b00_00);
    tick();
    exp_fc++;
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL br_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
`ifdef PIPE_HAZARD_PERF_EN
    n_chk++;
    if (hz.stall_cnt !== exp_sc || hz.flush_cnt !== exp_fc)
      $display("FAIL br_cnt got %0d/%0d want %0d/%0d",
               hz.stall_cnt, hz.flush_cnt, exp_sc, exp_fc);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_stall();
    idle(3);
    drv(1, 1, 0, 1, 0, 5, 1, 1, 0);
    tick();
    drv(1, 5, 5, 1, 1, 6, 1, 0, 0);
    #1;
    n_chk++;
    if (w_ctl !== 6'b110100) $display("FAIL rms_pre_ctl got %b want %b", w_ctl, 6'b110100);
    else n_pass++;
    rst_n = 1'b0;
    exp_sc = 0;
    exp_fc = 0;
    #1;
    n_chk++;
    if (w_ctl !== 6'b0) $display("FAIL rms_ctl got %b want %b", w_ctl, 6'b0);
    else n_pass++;
    n_chk++;
    if (w_fwd !== 4'h0) $display("FAIL rms_fwd got %b want %b", w_fwd, 4'h0);
    else n_pass++;
`ifdef PIPE_HAZARD_PERF_EN
    n_chk++;
    if (hz.stall_cnt !== 0 || hz.flush_cnt !== 0)
      $display("FAIL rms_cnt got %0d/%0d want 0/0", hz.stall_cnt, hz.flush_cnt);
    else n_pass++;
`endif
    #2;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (w_ctl !== 6'b0) $display("FAIL rms_post_ctl got %b want %b", w_ctl, 6'b0);
    else n_pass++;
    q_fwd.push_back(4'b00_00);
    tick();
    w_exp = q_fwd.pop_front();
    n_chk++;
    if (w_fwd !== w_exp) $display("FAIL rms_post_fwd got %b want %b", w_fwd, w_exp);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_fwd();
    test_youngest();
    test_load_use();
    test_bypass();
    test_r0();
    test_id_invalid();
    test_branch_stall();
    test_reset_mid_stall();
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
